nn_mac_engine: RTL and testbench
================================

Name: nn_mac_engine

Overview:
- Serial multiply-accumulate neuron core sitting directly downstream of wishbone_nn.
- wishbone_nn's register front-end starts an operation, streams (activation, weight) pairs, and reads back one quantized neuron output.
- Per operation: signed dot product plus bias, then ReLU, then right-shift and saturation to an unsigned DATA_W result.
- Valid/ready handshakes on both the input stream and the result.

Parameters:
- DATA_W, 8, signed activation/weight width; also the unsigned output width.
- ACC_W, 20, signed accumulator width; must be >= 2*DATA_W.
- LEN_W, 8, width of the beat-count field (max 2^LEN_W-1 beats).
- SHIFT, 4, arithmetic right shift applied after ReLU (output scaling).

Ports:
- wb_clk_i  in  1  clock (the Wishbone clock)
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- start_i  in  1  one-cycle start pulse; honoured only in IDLE
- len_i  in  LEN_W  number of (x,w) beats, sampled on start
- bias_i  in  ACC_W  signed bias, sampled on start
- in_valid_i  in  1  x_i/w_i valid
- in_ready_o  out  1  engine accepts a beat
- x_i  in  DATA_W  signed activation
- w_i  in  DATA_W  signed weight
- out_valid_o  out  1  y_o valid
- out_ready_i  in  1  consumer accepts y_o
- y_o  out  DATA_W  unsigned quantized result
- busy_o  out  1  high whenever state != IDLE
- sat_o  out  1  sticky saturation flag for the current/last operation

Behaviour:
- Reset (asynchronous, wb_rst_ni low):
  - state=IDLE.
  - acc, count, y_o, sat_o = 0.
  - in_ready_o, out_valid_o, busy_o = 0.
  - Reset mid-operation abandons the operation; no output is produced.
- FSM states: IDLE, ACC, (DRAIN, only with NN_MAC_PIPE_EN), OUT.
- IDLE:
  - On start_i: acc<=bias_i, count<=0, sat_o<=0, latch len_i.
  - len_i>0: go to ACC.
  - len_i==0: go straight to OUT; result is computed from the bias alone.
  - start_i is ignored in every non-IDLE state.
- ACC:
  - in_ready_o=1 (combinational from state).
  - A beat transfers when in_valid_i && in_ready_o.
  - Each beat: acc <= sat(acc + x_i*w_i), count++.
  - Product is the full signed 2*DATA_W value, sign-extended to ACC_W.
  - The sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sat_o<=1 when clamping occurs.
  - On the beat where count==len-1, go to OUT next cycle; in_ready_o drops in that same following cycle.
  - Gaps (in_valid_i low) simply stall.
- OUT:
  - out_valid_o=1.
  - y_o = min(max(acc,0) >>> SHIFT, 2^DATA_W-1); sat_o<=1 if this clamp is hit.
  - y_o is registered, stable while out_valid_o is high.
  - Held until out_ready_i; on the handshake go to IDLE.
  - out_valid_o never drops without a handshake.
- Latency: out_valid_o rises the cycle after the last accepted beat (two cycles with NN_MAC_PIPE_EN).
  - A back-to-back start_i is accepted in the cycle after the out handshake.
- Simultaneous in-beat and start_i: start_i is ignored (not IDLE).
- count uses LEN_W bits; it cannot wrap because the terminal compare happens first.

Optional Feature:
- Macro NN_MAC_PIPE_EN.
- When defined:
  - x_i*w_i is registered before accumulation (product register plus a valid bit).
  - After the last beat the FSM enters DRAIN for one cycle to add the final product, then OUT.
  - Throughput is unchanged (one beat/cycle); result latency is +1.
- When undefined: multiply and add happen in the same cycle, and DRAIN does not exist.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum (IDLE/ACC/DRAIN/OUT);
  - default widths (DATA_W, ACC_W, LEN_W);
  - a saturating-add function and a ReLU/shift/clamp quantize function, both parameterised by width.
- One natural sub-module: nn_sat_acc, the saturating accumulator register with its clamp flag.
- The FSM, counter and handshakes stay in nn_mac_engine.

Test Plan:
- Basic dot product: start with len=3, bias=10, SHIFT=0; beats (2,4),(3,5),(-1,6) -> 8+15-6+10=27; y_o=27, sat_o=0, out_valid_o exactly 1 cycle after the third beat.
- ReLU: len=1, bias=-100, beat (1,1) -> acc=-99; y_o=0, sat_o=0.
- Accumulator saturation: ACC_W=16, SHIFT=0, len=3, bias=0; beats (-128,-128)x3 -> acc clamps at 32767; sat_o=1, y_o=255.
- Handshakes:
  - in_valid_i toggles every other cycle -> same result as the continuous stream;
  - out_ready_i held low 5 cycles -> y_o/out_valid_o stable, busy_o=1;
  - start_i during ACC -> ignored.
- len=0 with bias=0x40, SHIFT=4 -> no beats accepted (in_ready_o never high); y_o=4.
- Reset mid-ACC after 2 of 4 beats -> all outputs 0, state IDLE; a new operation afterwards produces a correct result; repeat the whole suite with NN_MAC_PIPE_EN defined (latency +1).

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default widths and arithmetic helpers for the nn_mac_engine slice.
// Helpers work at 64 bits with a run-time width so any instance width up to 62 bits can share them.
package nn_pkg;

    localparam int unsigned NN_DATA_W = 8;
    localparam int unsigned NN_ACC_W  = 20;
    localparam int unsigned NN_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } nn_state_t;

    // Signed add clamped to the range of a w-bit two's complement value.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w,
                                                   output logic clamped);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum     = a + b;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (w - 1));
        clamped = 1'b0;
        if (sum > hi) begin
            sum     = hi;
            clamped = 1'b1;
        end else if (sum < lo) begin
            sum     = lo;
            clamped = 1'b1;
        end
        return sum;
    endfunction

    // ReLU, arithmetic right shift, then clamp to an unsigned w-bit value.
    function automatic logic [63:0] quantize(input logic signed [63:0] a,
                                             input int unsigned shift,
                                             input int unsigned w,
                                             output logic clamped);
        logic [63:0] r;
        logic [63:0] top;
        top     = (64'd1 << w) - 64'd1;
        r       = (a < 0) ? '0 : $unsigned(a >>> shift);
        clamped = (r > top);
        if (clamped) r = top;
        return r;
    endfunction

endpackage

// File: rtl/nn_mac_engine_if.sv
// nn_mac_engine_if: start/stream/result signals between the Wishbone front-end (master) and the engine (slave).
interface nn_mac_engine_if
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned ACC_W  = NN_ACC_W,
    parameter int unsigned LEN_W  = NN_LEN_W
);
    logic                     start_i;
    logic [LEN_W-1:0]         len_i;
    logic signed [ACC_W-1:0]  bias_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic signed [DATA_W-1:0] x_i;
    logic signed [DATA_W-1:0] w_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [DATA_W-1:0]        y_o;
    logic                     busy_o;
    logic                     sat_o;

    modport master (
        output start_i, len_i, bias_i, in_valid_i, x_i, w_i, out_ready_i,
        input  in_ready_o, out_valid_o, y_o, busy_o, sat_o
    );

    modport slave (
        input  start_i, len_i, bias_i, in_valid_i, x_i, w_i, out_ready_i,
        output in_ready_o, out_valid_o, y_o, busy_o, sat_o
    );
endinterface

// File: rtl/nn_sat_acc.sv
// nn_sat_acc: saturating accumulator register; exposes the next value so the
// caller can quantize it in the same cycle it is written.
module nn_sat_acc
    import nn_pkg::*;
#(
    parameter int unsigned ACC_W = NN_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic                    add_en,
    input  logic signed [ACC_W-1:0] addend,
    output logic signed [ACC_W-1:0] acc_nxt,
    output logic                    clamp
);
    logic signed [ACC_W-1:0] acc_q;
    logic signed [63:0]      sum;
    logic                    hit;

    always_comb begin
        acc_nxt = acc_q;
        clamp   = 1'b0;
        sum     = '0;
        hit     = 1'b0;
        if (load) begin
            acc_nxt = load_val;
        end else if (add_en) begin
            sum     = sat_add(64'(acc_q), 64'(addend), ACC_W, hit);
            acc_nxt = ACC_W'(sum);
            clamp   = hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_nxt;
    end
endmodule

// File: rtl/nn_mac_engine.sv
// nn_mac_engine: serial signed MAC neuron (bias + dot product, ReLU, shift, unsigned saturation).
// Optional macro NN_MAC_PIPE_EN registers the product and adds a one-cycle DRAIN state.
module nn_mac_engine
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned ACC_W  = NN_ACC_W,
    parameter int unsigned LEN_W  = NN_LEN_W,
    parameter int unsigned SHIFT  = 4
) (
    input logic            wb_clk_i,
    input logic            wb_rst_ni,
    nn_mac_engine_if.slave bus
);
    nn_state_t               state_q, state_d;
    logic [LEN_W-1:0]        count_q, len_q;
    logic [DATA_W-1:0]       y_q, y_d;
    logic                    sat_q, q_sat, acc_clamp;
    logic                    start_ok, beat, last_beat, y_load, add_en;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext, addend, acc_nxt;

    assign start_ok  = (state_q == IDLE) && bus.start_i;
    assign beat      = (state_q == ACC) && bus.in_valid_i;
    assign last_beat = (count_q == len_q - LEN_W'(1));
    assign prod      = bus.x_i * bus.w_i;
    assign prod_ext  = ACC_W'(prod);

`ifdef NN_MAC_PIPE_EN
    logic signed [ACC_W-1:0] prod_q;
    logic                    prod_v_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else begin
            prod_v_q <= beat;
            if (beat) prod_q <= prod_ext;
        end
    end

    assign add_en = prod_v_q;
    assign addend = prod_q;
`else
    assign add_en = beat;
    assign addend = prod_ext;
`endif

    nn_sat_acc #(.ACC_W(ACC_W)) u_acc (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (start_ok),
        .load_val (bus.bias_i),
        .add_en   (add_en),
        .addend   (addend),
        .acc_nxt  (acc_nxt),
        .clamp    (acc_clamp)
    );

    // Result is quantized from the accumulator value being written on the way into OUT.
    always_comb begin
        q_sat = 1'b0;
        y_d   = DATA_W'(quantize(64'(acc_nxt), SHIFT, DATA_W, q_sat));
    end

    always_comb begin
        state_d         = state_q;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.busy_o      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = (bus.len_i == '0) ? OUT : ACC;
            end
            ACC: begin
                bus.in_ready_o = 1'b1;
`ifdef NN_MAC_PIPE_EN
                if (beat && last_beat) state_d = DRAIN;
`else
                if (beat && last_beat) state_d = OUT;
`endif
            end
`ifdef NN_MAC_PIPE_EN
            DRAIN: state_d = OUT;
`endif
            OUT: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign y_load = (state_d == OUT) && (state_q != OUT);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                count_q <= '0;
                len_q   <= bus.len_i;
            end else if (beat) begin
                count_q <= count_q + LEN_W'(1);
            end
            // A zero-length start clears the flag and may set it again from the bias quantization.
            if (start_ok)                          sat_q <= y_load && q_sat;
            else if (acc_clamp || (y_load && q_sat)) sat_q <= 1'b1;
            if (y_load) y_q <= y_d;
        end
    end

    assign bus.y_o   = y_q;
    assign bus.sat_o = sat_q;
endmodule

// File: tb/tb_nn_mac_engine.sv
// tb_nn_mac_engine: directed vectors against three engine configurations sharing one stimulus stream.
module tb_nn_mac_engine;
`ifdef NN_MAC_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        len = '0;
    logic signed [19:0] bias = '0;
    logic              in_valid = 1'b0;
    logic signed [7:0] x = '0;
    logic signed [7:0] w = '0;
    logic              out_ready = 1'b0;
    logic signed [7:0] bx [4];
    logic signed [7:0] bw [4];
    int unsigned       n_cmp = 0;
    int unsigned       n_err = 0;

    always #5 clk = ~clk;

    // if0: ACC_W 20 / SHIFT 0, if1: ACC_W 16 / SHIFT 0, if2: ACC_W 20 / SHIFT 4
    nn_mac_engine_if #(.DATA_W(8), .ACC_W(20), .LEN_W(8)) if0 ();
    nn_mac_engine_if #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) if1 ();
    nn_mac_engine_if #(.DATA_W(8), .ACC_W(20), .LEN_W(8)) if2 ();

    assign if0.start_i = start;  assign if0.len_i = len;  assign if0.bias_i = bias;
    assign if0.in_valid_i = in_valid;  assign if0.x_i = x;  assign if0.w_i = w;
    assign if0.out_ready_i = out_ready;
    assign if1.start_i = start;  assign if1.len_i = len;  assign if1.bias_i = 16'(bias);
    assign if1.in_valid_i = in_valid;  assign if1.x_i = x;  assign if1.w_i = w;
    assign if1.out_ready_i = out_ready;
    assign if2.start_i = start;  assign if2.len_i = len;  assign if2.bias_i = bias;
    assign if2.in_valid_i = in_valid;  assign if2.x_i = x;  assign if2.w_i = w;
    assign if2.out_ready_i = out_ready;

    nn_mac_engine #(.DATA_W(8), .ACC_W(20), .LEN_W(8), .SHIFT(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if0.slave));
    nn_mac_engine #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SHIFT(0)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if1.slave));
    nn_mac_engine #(.DATA_W(8), .ACC_W(20), .LEN_W(8), .SHIFT(4)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if2.slave));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l, input logic signed [19:0] b);
        start = 1'b1;
        len   = l;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int  i   = 0;
        int  cyc = 0;
        bit  took;
        while (i < n && cyc < 100) begin
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            x        = bx[i];
            w        = bw[i];
            took     = in_valid && if0.in_ready_o;
            @(posedge clk); #1;
            cyc++;
            if (took) i++;
        end
        in_valid = 1'b0;
        if (i < n) check_val("feed_timeout", i, n);
    endtask

    task automatic wait_out(input string tag);
        int lat = 0;
        while (!if0.out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, lat, LAT);
    endtask

    task automatic take_out(input string tag, input logic [7:0] exp_y, input logic exp_sat, input int hold);
        out_ready = 1'b0;
        check_val({tag, "_y"}, if0.y_o, exp_y);
        check_val({tag, "_sat"}, if0.sat_o, exp_sat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, if0.out_valid_o, 1);
            check_val({tag, "_hold_y"}, if0.y_o, exp_y);
            check_val({tag, "_hold_busy"}, if0.busy_o, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_idle_busy"}, if0.busy_o, 0);
        check_val({tag, "_idle_valid"}, if0.out_valid_o, 0);
    endtask

    task automatic load_basic();
        bx[0] = 8'sd2;  bw[0] = 8'sd4;
        bx[1] = 8'sd3;  bw[1] = 8'sd5;
        bx[2] = -8'sd1; bw[2] = 8'sd6;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", if0.in_ready_o, 0);
        check_val("rst_out_valid", if0.out_valid_o, 0);
        check_val("rst_busy", if0.busy_o, 0);
        check_val("rst_y", if0.y_o, 0);
        check_val("rst_sat", if0.sat_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8 + 15 - 6 + 10 = 27
        load_basic();
        do_start(8'd3, 20'sd10);
        check_val("basic_busy", if0.busy_o, 1);
        feed(3, 1'b0);
        wait_out("basic");
        check_val("basic_y_acc16", if1.y_o, 27);
        check_val("basic_y_shift4", if2.y_o, 1);
        take_out("basic", 8'd27, 1'b0, 0);

        // -100 + 1 = -99 -> ReLU to 0
        bx[0] = 8'sd1; bw[0] = 8'sd1;
        do_start(8'd1, -20'sd100);
        feed(1, 1'b0);
        wait_out("relu");
        take_out("relu", 8'd0, 1'b0, 0);

        load_basic();
        do_start(8'd3, 20'sd10);
        feed(3, 1'b1);
        wait_out("gaps");
        take_out("gaps", 8'd27, 1'b0, 5);

        // stray start (len 0, bias 500) during ACC must be ignored; 9 + 4 = 13
        bx[0] = 8'sd3; bw[0] = 8'sd3;
        bx[1] = 8'sd2; bw[1] = 8'sd2;
        do_start(8'd2, 20'sd0);
        do_start(8'd0, 20'sd500);
        check_val("stray_in_ready", if0.in_ready_o, 1);
        check_val("stray_out_valid", if0.out_valid_o, 0);
        feed(2, 1'b0);
        wait_out("stray");
        take_out("stray", 8'd13, 1'b0, 0);

        // len 0, bias 0x40: SHIFT 4 gives 4, SHIFT 0 gives 64
        do_start(8'd0, 20'sh40);
        check_val("len0_in_ready", if0.in_ready_o, 0);
        check_val("len0_valid", if0.out_valid_o, 1);
        check_val("len0_y_shift4", if2.y_o, 4);
        check_val("len0_y_acc16", if1.y_o, 64);
        take_out("len0", 8'd64, 1'b0, 0);

        // 3 x (-16256): 16-bit acc clamps at -32768 -> y 0 but sat set; 20-bit acc does not clamp
        for (int i = 0; i < 3; i++) begin
            bx[i] = -8'sd128;
            bw[i] = 8'sd127;
        end
        do_start(8'd3, 20'sd0);
        feed(3, 1'b0);
        wait_out("negsat");
        check_val("negsat_y_acc16", if1.y_o, 0);
        check_val("negsat_sat_acc16", if1.sat_o, 1);
        check_val("negsat_sat_shift4", if2.sat_o, 0);
        take_out("negsat", 8'd0, 1'b0, 0);

        // 3 x 16384: 16-bit acc clamps at 32767; every config clamps y to 255
        for (int i = 0; i < 3; i++) begin
            bx[i] = -8'sd128;
            bw[i] = -8'sd128;
        end
        do_start(8'd3, 20'sd0);
        feed(3, 1'b0);
        wait_out("possat");
        check_val("possat_y_acc16", if1.y_o, 255);
        check_val("possat_sat_acc16", if1.sat_o, 1);
        check_val("possat_y_shift4", if2.y_o, 255);
        take_out("possat", 8'd255, 1'b1, 0);

        // abandon an operation after 2 of 4 beats
        for (int i = 0; i < 2; i++) begin
            bx[i] = 8'sd5;
            bw[i] = 8'sd5;
        end
        do_start(8'd4, 20'sd0);
        feed(2, 1'b0);
        check_val("mid_in_ready", if0.in_ready_o, 1);
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_in_ready", if0.in_ready_o, 0);
        check_val("mid_rst_out_valid", if0.out_valid_o, 0);
        check_val("mid_rst_busy", if0.busy_o, 0);
        check_val("mid_rst_y", if0.y_o, 0);
        check_val("mid_rst_sat", if0.sat_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_basic();
        do_start(8'd3, 20'sd10);
        feed(3, 1'b0);
        wait_out("post_rst");
        take_out("post_rst", 8'd27, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
